// File: rtl/ctrl_pipe_decoder.sv
// rtl/ctrl_pipe_decoder.sv - pipelined control decoder with hazard, flush and mult/div sequencing
module ctrl_pipe_decoder #(
    parameter int          OPW    = 5,
    parameter int          RW     = 5,
    parameter logic [4:0]  MUL_OP = 5'b00110,
    parameter logic [4:0]  DIV_OP = 5'b00111
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_d_valid,
    input  logic [OPW-1:0] i_d_opcode,
    input  logic [4:0]     i_d_aluop,
    input  logic [RW-1:0]  i_d_rd,
    input  logic [RW-1:0]  i_d_rs,
    input  logic [RW-1:0]  i_d_rt,
    input  logic           i_br_taken,
    input  logic           i_md_ready,
    output logic           o_stall,
    output logic           o_flush,
    output logic           o_md_start,
    output logic           o_illegal,
    output logic [10:0]    o_x_ctrl,
    output logic [10:0]    o_m_ctrl,
    output logic [10:0]    o_w_ctrl,
    output logic [RW-1:0]  o_x_rd,
    output logic [RW-1:0]  o_m_rd,
    output logic [RW-1:0]  o_w_rd,
    output logic           o_x_valid,
    output logic           o_m_valid,
    output logic           o_w_valid
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MD_BUSY = 1'b1;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_J     = OPW'(1);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(5);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(6);
    localparam logic [OPW-1:0] OP_SW    = OPW'(7);
    localparam logic [OPW-1:0] OP_LW    = OPW'(8);

    // Bit 2 (Rwd) marks a load: its result is only available after M.
    localparam int LOAD_BIT = 2;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [10:0]   r_x_ctrl, r_m_ctrl, r_w_ctrl;
    logic [RW-1:0] r_x_rd, r_m_rd, r_w_rd;
    logic          r_x_valid, r_m_valid, r_w_valid;
    logic          r_md_start;
    logic          r_illegal;

    logic [10:0]   w_dec_ctrl;
    logic          w_dec_legal;
    logic          w_is_idle;
    logic          w_load_use;
    logic          w_flush;
    logic          w_stall;
    logic          w_is_md;
    logic          w_issue_md;
    logic          w_x_bubble;

    always_comb begin
        w_dec_ctrl  = 11'h000;
        w_dec_legal = 1'b1;
        case (i_d_opcode)
            OP_RTYPE: w_dec_ctrl = 11'h280;
            OP_J:     w_dec_ctrl = 11'h001;
            OP_BNE:   w_dec_ctrl = 11'h052;
            OP_JAL:   w_dec_ctrl = 11'h181;
            OP_ADDI:  w_dec_ctrl = 11'h0A0;
            OP_BLT:   w_dec_ctrl = 11'h450;
            OP_SW:    w_dec_ctrl = 11'h068;
            OP_LW:    w_dec_ctrl = 11'h0A4;
            default:  w_dec_legal = 1'b0;
        endcase
    end

    assign w_is_idle  = (r_state == S_IDLE);
    assign w_load_use = i_d_valid & r_x_valid & r_x_ctrl[LOAD_BIT] & (r_x_rd != '0)
                      & ((r_x_rd == i_d_rs) | (r_x_rd == i_d_rt));
    // Flush is masked during reset so nothing downstream sees a stray discard.
    assign w_flush    = i_rst_n & w_is_idle & i_br_taken;
    assign w_stall    = ~w_is_idle | (w_load_use & ~w_flush);
    assign w_is_md    = (i_d_opcode == OP_RTYPE) & ((i_d_aluop == MUL_OP) | (i_d_aluop == DIV_OP));
    assign w_issue_md = w_is_idle & ~w_flush & ~w_load_use & i_d_valid & w_is_md;
    assign w_x_bubble = w_flush | w_stall | ~i_d_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_issue_md) w_state_nxt = S_MD_BUSY;
            S_MD_BUSY: if (i_md_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_md_start <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_md_start <= w_issue_md;
            r_illegal  <= i_d_valid & ~w_dec_legal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_ctrl  <= '0;
            r_x_rd    <= '0;
            r_x_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_rd    <= '0;
            r_m_valid <= 1'b0;
            r_w_ctrl  <= '0;
            r_w_rd    <= '0;
            r_w_valid <= 1'b0;
        end else begin
            r_w_ctrl  <= r_m_ctrl;
            r_w_rd    <= r_m_rd;
            r_w_valid <= r_m_valid;
            if (!w_is_idle) begin
                // Mult/div occupies X; M receives bubbles until the unit is done.
                r_m_ctrl  <= '0;
                r_m_rd    <= '0;
                r_m_valid <= 1'b0;
            end else begin
                r_m_ctrl  <= r_x_ctrl;
                r_m_rd    <= r_x_rd;
                r_m_valid <= r_x_valid;
                if (w_x_bubble) begin
                    r_x_ctrl  <= '0;
                    r_x_rd    <= '0;
                    r_x_valid <= 1'b0;
                end else begin
                    r_x_ctrl  <= w_dec_ctrl;
                    r_x_rd    <= i_d_rd;
                    r_x_valid <= 1'b1;
                end
            end
        end
    end

    assign o_stall    = w_stall;
    assign o_flush    = w_flush;
    assign o_md_start = r_md_start;
    assign o_illegal  = r_illegal;
    assign o_x_ctrl   = r_x_ctrl;
    assign o_m_ctrl   = r_m_ctrl;
    assign o_w_ctrl   = r_w_ctrl;
    assign o_x_rd     = r_x_rd;
    assign o_m_rd     = r_m_rd;
    assign o_w_rd     = r_w_rd;
    assign o_x_valid  = r_x_valid;
    assign o_m_valid  = r_m_valid;
    assign o_w_valid  = r_w_valid;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// tb/tb_ctrl_pipe_decoder.sv - directed plus randomized checks against a stage-list reference model
module tb_ctrl_pipe_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        d_valid;
    logic [4:0]  d_opcode, d_aluop, d_rd, d_rs, d_rt;
    logic        br_taken, md_ready;
    logic        stall, flush, md_start, illegal;
    logic [10:0] x_ctrl, m_ctrl, w_ctrl;
    logic [4:0]  x_rd, m_rd, w_rd;
    logic        x_valid, m_valid, w_valid;

    ctrl_pipe_decoder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d_valid  (d_valid),
        .i_d_opcode (d_opcode),
        .i_d_aluop  (d_aluop),
        .i_d_rd     (d_rd),
        .i_d_rs     (d_rs),
        .i_d_rt     (d_rt),
        .i_br_taken (br_taken),
        .i_md_ready (md_ready),
        .o_stall    (stall),
        .o_flush    (flush),
        .o_md_start (md_start),
        .o_illegal  (illegal),
        .o_x_ctrl   (x_ctrl),
        .o_m_ctrl   (m_ctrl),
        .o_w_ctrl   (w_ctrl),
        .o_x_rd     (x_rd),
        .o_m_rd     (m_rd),
        .o_w_rd     (w_rd),
        .o_x_valid  (x_valid),
        .o_m_valid  (m_valid),
        .o_w_valid  (w_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        v;
        logic [10:0] c;
        logic [4:0]  rd;
    } stage_t;

    stage_t      ex, em, ew;
    bit          e_busy, e_start, e_illegal;
    logic [10:0] ctrl_tbl [32];
    bit          legal_tbl [32];
    int          legal_ops [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

    task automatic def_op(input int op, input int mask);
        ctrl_tbl[op]  = mask[10:0];
        legal_tbl[op] = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_hazard();
        return d_valid && ex.v && ex.c[2] && ex.rd != 0 && (ex.rd == d_rs || ex.rd == d_rt);
    endfunction

    function automatic bit exp_flush();
        return rst_n && !e_busy && br_taken;
    endfunction

    function automatic bit exp_stall();
        return e_busy || (exp_hazard() && !exp_flush());
    endfunction

    task automatic model_reset();
        ex = '0; em = '0; ew = '0;
        e_busy = 0; e_start = 0; e_illegal = 0;
    endtask

    task automatic model_clock();
        bit fl, st;
        fl = exp_flush();
        st = exp_stall();
        e_illegal = d_valid && !legal_tbl[d_opcode];
        ew = em;
        if (e_busy) begin
            em = '0;
            e_start = 0;
            if (md_ready) e_busy = 0;
        end else if (fl || st) begin
            em = ex;
            ex = '0;
            e_start = 0;
        end else begin
            em = ex;
            ex = d_valid ? {1'b1, ctrl_tbl[d_opcode], d_rd} : '0;
            e_start = d_valid && d_opcode == 0 && (d_aluop == 6 || d_aluop == 7);
            e_busy = e_start;
        end
    endtask

    task automatic check_comb();
        check("stall", stall, exp_stall());
        check("flush", flush, exp_flush());
    endtask

    task automatic check_regs();
        check("x_ctrl", x_ctrl, ex.c);
        check("x_rd", x_rd, ex.rd);
        check("x_valid", x_valid, ex.v);
        check("m_ctrl", m_ctrl, em.c);
        check("m_rd", m_rd, em.rd);
        check("m_valid", m_valid, em.v);
        check("w_ctrl", w_ctrl, ew.c);
        check("w_rd", w_rd, ew.rd);
        check("w_valid", w_valid, ew.v);
        check("md_start", md_start, e_start);
        check("illegal", illegal, e_illegal);
    endtask

    task automatic step();
        #2 check_comb();
        @(posedge clk);
        model_clock();
        #1 check_regs();
    endtask

    task automatic drive(input bit v, input int op, input int alu, input int rd, input int rs, input int rt);
        d_valid  = v;
        d_opcode = op[4:0];
        d_aluop  = alu[4:0];
        d_rd     = rd[4:0];
        d_rs     = rs[4:0];
        d_rt     = rt[4:0];
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        check("rst_stall", stall, 0);
        check("rst_flush", flush, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ctrl_tbl[i]  = '0;
            legal_tbl[i] = 1'b0;
        end
        def_op(0, (1 << 9) | (1 << 7));
        def_op(1, (1 << 0));
        def_op(2, (1 << 6) | (1 << 4) | (1 << 1));
        def_op(3, (1 << 0) | (1 << 7) | (1 << 8));
        def_op(5, (1 << 7) | (1 << 5));
        def_op(6, (1 << 6) | (1 << 4) | (1 << 10));
        def_op(7, (1 << 6) | (1 << 5) | (1 << 3));
        def_op(8, (1 << 7) | (1 << 5) | (1 << 2));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        br_taken = 1'b1;
        md_ready = 1'b0;
        model_reset();
        #3;
        check_regs();
        check_comb();
        check("rst_flush", flush, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        br_taken = 1'b0;

        drive(1, 5, 0, 1, 0, 0); step(); check("addi_x", x_ctrl, 'h0A0);
        drive(1, 7, 0, 0, 1, 2); step(); check("sw_x", sw_dummy(x_ctrl), 'h068);
        drive(1, 8, 0, 3, 1, 0); step(); check("lw_x", x_ctrl, 'h0A4);
        check("addi_w", w_ctrl, 'h0A0);

        drive(1, 0, 0, 5, 3, 4);
        #2 check("lu_stall", stall, 1);
        step();
        check("lu_bubble_v", x_valid, 0);
        check("lu_bubble_c", x_ctrl, 0);
        check("sw_w", w_ctrl, 'h068);
        #2 check("lu_release", stall, 0);
        step();
        check("add_x", x_ctrl, 'h280);
        check("lw_w", w_ctrl, 'h0A4);

        drive(1, 8, 0, 0, 1, 1); step();
        drive(1, 0, 0, 6, 0, 0);
        #2 check("r0_stall", stall, 0);
        step();

        drive(1, 2, 0, 0, 1, 2); step();
        drive(1, 3, 0, 7, 0, 0);
        br_taken = 1'b1;
        #2 check("br_flush", flush, 1);
        step();
        check("br_xv", x_valid, 0);
        br_taken = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("jal_m", m_valid, 0);

        drive(1, 0, 6, 4, 1, 2); step();
        check("mul_start", md_start, 1);
        check("mul_x", x_ctrl, 'h280);
        drive(1, 5, 0, 9, 4, 4);
        for (int i = 0; i < 5; i++) begin
            #2 check("mul_stall", stall, 1);
            step();
            check("mul_mv", m_valid, 0);
            check("mul_start_once", md_start, 0);
        end
        md_ready = 1'b1;
        #2 check("mul_rdy_stall", stall, 1);
        step();
        md_ready = 1'b0;
        #2 check("mul_done_stall", stall, 0);
        check("mul_hold_x", x_ctrl, 'h280);
        step();
        check("mul_m", m_ctrl, 'h280);
        check("mul_m_rd", m_rd, 4);
        check("after_mul_x", x_ctrl, 'h0A0);

        drive(1, 0, 7, 2, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        br_taken = 1'b1;
        reset_now();
        br_taken = 1'b0;
        md_ready = 1'b1;
        #2 check("post_rst_stall", stall, 0);
        step();
        md_ready = 1'b0;
        check("post_rst_xv", x_valid, 0);
        step();

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            d_opcode = (r < 8) ? 5'(legal_ops[r]) : 5'($urandom_range(0, 31));
            d_aluop  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(6, 7)) : 5'($urandom_range(0, 31));
            d_rd     = 5'($urandom_range(0, 3));
            d_rs     = 5'($urandom_range(0, 3));
            d_rt     = 5'($urandom_range(0, 3));
            d_valid  = ($urandom_range(0, 4) != 0);
            br_taken = ($urandom_range(0, 7) == 0);
            md_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0)
                reset_now();
            else
                step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [10:0] sw_dummy(input logic [10:0] v);
        return v;
    endfunction

endmodule
